// File: rtl/spi_display_rx_if.sv
// Pin-level bundle for the ST7735-style SPI display receiver: async SPI inputs
// toward the receiver and the decoded command/window/pixel outputs back out.
interface spi_display_rx_if #(
  parameter int BYTES_PER_PX = 2,
  parameter int COORD_W      = 10
);
  logic                      i_spi_clk;
  logic                      i_spi_cs;
  logic                      i_spi_mosi;
  logic                      i_dc;
  logic [7:0]                o_inst_data;
  logic                      o_inst_en_pls;
  logic [31:0]               o_col_addr;
  logic                      o_col_addr_en_pls;
  logic [31:0]               o_row_addr;
  logic                      o_row_addr_en_pls;
  logic [8*BYTES_PER_PX-1:0] o_pixel_data;
  logic [COORD_W-1:0]        o_pixel_x;
  logic [COORD_W-1:0]        o_pixel_y;
  logic                      o_pixel_en_pls;
  logic                      o_pixel_first;
  logic                      o_pixel_last;
  logic                      o_disp_on;
  logic                      o_swreset_pls;
  logic                      o_frame_err_pls;

  modport slave (
    input  i_spi_clk, i_spi_cs, i_spi_mosi, i_dc,
    output o_inst_data, o_inst_en_pls, o_col_addr, o_col_addr_en_pls,
           o_row_addr, o_row_addr_en_pls, o_pixel_data, o_pixel_x, o_pixel_y,
           o_pixel_en_pls, o_pixel_first, o_pixel_last, o_disp_on,
           o_swreset_pls, o_frame_err_pls
  );

  modport master (
    output i_spi_clk, i_spi_cs, i_spi_mosi, i_dc,
    input  o_inst_data, o_inst_en_pls, o_col_addr, o_col_addr_en_pls,
           o_row_addr, o_row_addr_en_pls, o_pixel_data, o_pixel_x, o_pixel_y,
           o_pixel_en_pls, o_pixel_first, o_pixel_last, o_disp_on,
           o_swreset_pls, o_frame_err_pls
  );
endinterface

// File: rtl/spi_display_rx.sv
// ST7735-style SPI (mode 0) receiver oversampled in i_clk: decodes commands,
// CASET/RASET windows and RAMWR pixel streams with (x,y) walked inside the window.
module spi_display_rx #(
  parameter int SYNC_STAGES  = 2,
  parameter int BYTES_PER_PX = 2,
  parameter int COORD_W      = 10,
  parameter int DEF_XE       = 127,
  parameter int DEF_YE       = 159
) (
  input logic            i_clk,
  input logic            i_rst_n,
  spi_display_rx_if.slave bus
);
  localparam int         PXW     = 8 * BYTES_PER_PX;
  localparam logic [15:0] XE_RST = 16'(DEF_XE);
  localparam logic [15:0] YE_RST = 16'(DEF_YE);
  localparam logic [1:0]  PX_LAST = 2'(BYTES_PER_PX - 1);

  localparam logic [7:0] CMD_SWRESET = 8'h01;
  localparam logic [7:0] CMD_DISPOFF = 8'h28;
  localparam logic [7:0] CMD_DISPON  = 8'h29;
  localparam logic [7:0] CMD_CASET   = 8'h2A;
  localparam logic [7:0] CMD_RASET   = 8'h2B;
  localparam logic [7:0] CMD_RAMWR   = 8'h2C;

  // ---------------- synchronisers ----------------
  logic [SYNC_STAGES-1:0] sck_sync_q, cs_sync_q, mosi_sync_q, dc_sync_q;
  logic                   sck_dly_q, cs_dly_q;
  logic                   sck_s, cs_s, mosi_s, dc_s, sck_rise, cs_rise;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      sck_sync_q  <= '0;
      cs_sync_q   <= '0;
      mosi_sync_q <= '0;
      dc_sync_q   <= '0;
      sck_dly_q   <= 1'b0;
      cs_dly_q    <= 1'b0;
    end else begin
      sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0],  bus.i_spi_clk};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0],   bus.i_spi_cs};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], bus.i_spi_mosi};
      dc_sync_q   <= {dc_sync_q[SYNC_STAGES-2:0],   bus.i_dc};
      sck_dly_q   <= sck_s;
      cs_dly_q    <= cs_s;
    end
  end

  assign sck_s    = sck_sync_q[SYNC_STAGES-1];
  assign cs_s     = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s   = mosi_sync_q[SYNC_STAGES-1];
  assign dc_s     = dc_sync_q[SYNC_STAGES-1];
  assign sck_rise = sck_s & ~sck_dly_q;
  assign cs_rise  = cs_s & ~cs_dly_q;

  // ---------------- byte assembly ----------------
  logic [2:0] bit_cnt_q;
  logic [6:0] shift_q;
  logic [7:0] byte_q;
  logic       byte_vld_q, byte_dc_q;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      byte_q     <= '0;
      byte_vld_q <= 1'b0;
      byte_dc_q  <= 1'b0;
    end else begin
      byte_vld_q <= 1'b0;
      if (cs_s) begin
        bit_cnt_q <= '0;
      end else if (sck_rise) begin
        shift_q   <= {shift_q[5:0], mosi_s};
        bit_cnt_q <= bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd7) begin
          byte_q     <= {shift_q, mosi_s};
          byte_vld_q <= 1'b1;
          byte_dc_q  <= dc_s;
        end
      end
    end
  end

  // ---------------- decode state ----------------
  logic [7:0]         inst_q;
  logic               inst_en_q, col_en_q, row_en_q, pix_en_q, swreset_q, frame_err_q;
  logic [31:0]        col_q, row_q;
  logic [2:0]         param_cnt_q;
  logic [1:0]         pix_cnt_q;
  logic [PXW-9:0]     acc_q;
  logic [PXW-1:0]     pix_data_q, px_word;
  logic [COORD_W-1:0] pix_x_q, pix_y_q, x_q, y_q;
  logic [COORD_W-1:0] win_xs_q, win_xe_q, win_ys_q, win_ye_q;
  logic               first_q, first_out_q, last_out_q, disp_on_q;
  logic [COORD_W-1:0] x_d, y_d;
  logic               last_d;

  assign px_word = {acc_q, byte_q};

  // Walk inside the window latched at RAMWR; >= keeps a degenerate XS>XE window sane.
  always_comb begin
    x_d    = x_q + COORD_W'(1);
    y_d    = y_q;
    last_d = 1'b0;
    if (x_q >= win_xe_q) begin
      x_d = win_xs_q;
      if (y_q >= win_ye_q) begin
        y_d    = win_ys_q;
        last_d = 1'b1;
      end else begin
        y_d = y_q + COORD_W'(1);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      inst_q      <= '0;
      inst_en_q   <= 1'b0;
      col_en_q    <= 1'b0;
      row_en_q    <= 1'b0;
      pix_en_q    <= 1'b0;
      swreset_q   <= 1'b0;
      frame_err_q <= 1'b0;
      col_q       <= {16'h0000, XE_RST};
      row_q       <= {16'h0000, YE_RST};
      param_cnt_q <= '0;
      pix_cnt_q   <= '0;
      acc_q       <= '0;
      pix_data_q  <= '0;
      pix_x_q     <= '0;
      pix_y_q     <= '0;
      x_q         <= '0;
      y_q         <= '0;
      win_xs_q    <= '0;
      win_xe_q    <= XE_RST[COORD_W-1:0];
      win_ys_q    <= '0;
      win_ye_q    <= YE_RST[COORD_W-1:0];
      first_q     <= 1'b0;
      first_out_q <= 1'b0;
      last_out_q  <= 1'b0;
      disp_on_q   <= 1'b0;
    end else begin
      inst_en_q   <= 1'b0;
      col_en_q    <= 1'b0;
      row_en_q    <= 1'b0;
      pix_en_q    <= 1'b0;
      swreset_q   <= 1'b0;
      frame_err_q <= cs_rise && (bit_cnt_q != 3'd0 || pix_cnt_q != 2'd0);
      if (cs_s) pix_cnt_q <= '0;

      if (byte_vld_q && !byte_dc_q) begin
        inst_q      <= byte_q;
        inst_en_q   <= 1'b1;
        param_cnt_q <= '0;
        pix_cnt_q   <= '0;
        case (byte_q)
          CMD_SWRESET: begin
            swreset_q <= 1'b1;
            disp_on_q <= 1'b0;
            col_q     <= {16'h0000, XE_RST};
            row_q     <= {16'h0000, YE_RST};
          end
          CMD_DISPOFF: disp_on_q <= 1'b0;
          CMD_DISPON:  disp_on_q <= 1'b1;
          CMD_RAMWR: begin
            win_xs_q <= col_q[16 +: COORD_W];
            win_xe_q <= col_q[0  +: COORD_W];
            win_ys_q <= row_q[16 +: COORD_W];
            win_ye_q <= row_q[0  +: COORD_W];
            x_q      <= col_q[16 +: COORD_W];
            y_q      <= row_q[16 +: COORD_W];
            first_q  <= 1'b1;
          end
          default: ;
        endcase
      end else if (byte_vld_q) begin
        case (inst_q)
          CMD_CASET: if (param_cnt_q < 3'd4) begin
            col_q       <= {col_q[23:0], byte_q};
            param_cnt_q <= param_cnt_q + 3'd1;
            col_en_q    <= (param_cnt_q == 3'd3);
          end
          CMD_RASET: if (param_cnt_q < 3'd4) begin
            row_q       <= {row_q[23:0], byte_q};
            param_cnt_q <= param_cnt_q + 3'd1;
            row_en_q    <= (param_cnt_q == 3'd3);
          end
          CMD_RAMWR: begin
            if (pix_cnt_q == PX_LAST) begin
              pix_cnt_q   <= '0;
              pix_en_q    <= 1'b1;
              pix_data_q  <= px_word;
              pix_x_q     <= x_q;
              pix_y_q     <= y_q;
              first_out_q <= first_q;
              last_out_q  <= last_d;
              first_q     <= 1'b0;
              x_q         <= x_d;
              y_q         <= y_d;
            end else begin
              pix_cnt_q <= pix_cnt_q + 2'd1;
              acc_q     <= px_word[PXW-9:0];
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.o_inst_data       = inst_q;
  assign bus.o_inst_en_pls     = inst_en_q;
  assign bus.o_col_addr        = col_q;
  assign bus.o_col_addr_en_pls = col_en_q;
  assign bus.o_row_addr        = row_q;
  assign bus.o_row_addr_en_pls = row_en_q;
  assign bus.o_pixel_data      = pix_data_q;
  assign bus.o_pixel_x         = pix_x_q;
  assign bus.o_pixel_y         = pix_y_q;
  assign bus.o_pixel_en_pls    = pix_en_q;
  assign bus.o_pixel_first     = first_out_q;
  assign bus.o_pixel_last      = last_out_q;
  assign bus.o_disp_on         = disp_on_q;
  assign bus.o_swreset_pls     = swreset_q;
  assign bus.o_frame_err_pls   = frame_err_q;
endmodule
